// File: rtl/bcd_to_7segment_pkg.sv
// Shared segment patterns for the BCD seven-segment decoder.
// Bit order of every pattern is {A,B,C,D,E,F,G}, lit = 1 before polarity is applied.
package bcd_to_7segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Common-anode displays need every segment inverted, blank value included.
  function automatic logic [6:0] apply_polarity(input logic [6:0] seg, input bit active_low);
    return seg ^ {7{active_low}};
  endfunction

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational BCD digit to segment pattern lookup; non-BCD codes map to blank.
module bcd_seg_lut
  import bcd_to_7segment_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_to_7segment.sv
// Registered BCD to seven-segment decoder driving one digit, with selectable
// common-cathode (ACTIVE_LOW=0) or common-anode (ACTIVE_LOW=1) polarity.
module bcd_to_7segment
  import bcd_to_7segment_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic D3,
  input  logic D2,
  input  logic D1,
  input  logic D0,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G
);

  logic [3:0] w_bcd;
  logic [6:0] w_seg;
  logic [6:0] w_drive;
  logic [6:0] w_blank;
  logic [6:0] r_seg;

  assign w_bcd = {D3, D2, D1, D0};

  bcd_seg_lut u_lut (
    .i_bcd (w_bcd),
    .o_seg (w_seg)
  );

  assign w_drive = apply_polarity(w_seg, ACTIVE_LOW);
  assign w_blank = apply_polarity(SEG_BLANK, ACTIVE_LOW);

  // Output register keeps pin drive glitch-free; reset blanks the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= w_blank;
    end else begin
      r_seg <= w_drive;
    end
  end

  assign {A, B, C, D, E, F, G} = r_seg;

endmodule

// File: tb/tb_bcd_to_7segment.sv
// Directed bench for bcd_to_7segment: one common-cathode and one common-anode
// instance share the same stimulus and are checked against hand-written patterns.
module tb_bcd_to_7segment;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] bcd = 4'd0;
  logic a0, b0, c0, d0, e0, f0, g0;
  logic a1, b1, c1, d1, e1, f1, g1;
  logic [6:0] seg_cc;
  logic [6:0] seg_ca;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] in_bcd;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  bcd_to_7segment #(.ACTIVE_LOW(1'b0)) dut_cc (
    .clk(clk), .rst(rst),
    .D3(bcd[3]), .D2(bcd[2]), .D1(bcd[1]), .D0(bcd[0]),
    .A(a0), .B(b0), .C(c0), .D(d0), .E(e0), .F(f0), .G(g0)
  );

  bcd_to_7segment #(.ACTIVE_LOW(1'b1)) dut_ca (
    .clk(clk), .rst(rst),
    .D3(bcd[3]), .D2(bcd[2]), .D1(bcd[1]), .D0(bcd[0]),
    .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1)
  );

  assign seg_cc = {a0, b0, c0, d0, e0, f0, g0};
  assign seg_ca = {a1, b1, c1, d1, e1, f1, g1};

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Checks both builds: common-anode expects the bitwise inverse.
  task automatic chk_both(input string name, input logic [6:0] exp_cc);
    chk({name, "_cc"}, seg_cc, exp_cc);
    chk({name, "_ca"}, seg_ca, ~exp_cc);
  endtask

  task automatic drive_and_clock(input logic r, input logic [3:0] v);
    @(negedge clk);
    rst = r;
    bcd = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  7'b1111110};
    vecs[1]  = '{4'd1,  7'b0110000};
    vecs[2]  = '{4'd2,  7'b1101101};
    vecs[3]  = '{4'd3,  7'b1111001};
    vecs[4]  = '{4'd4,  7'b0110011};
    vecs[5]  = '{4'd5,  7'b1011011};
    vecs[6]  = '{4'd6,  7'b1011111};
    vecs[7]  = '{4'd7,  7'b1110000};
    vecs[8]  = '{4'd8,  7'b1111111};
    vecs[9]  = '{4'd9,  7'b1111011};
    vecs[10] = '{4'd10, 7'b0000000};
    vecs[11] = '{4'd11, 7'b0000000};
    vecs[12] = '{4'd12, 7'b0000000};
    vecs[13] = '{4'd13, 7'b0000000};
    vecs[14] = '{4'd14, 7'b0000000};
    vecs[15] = '{4'd15, 7'b0000000};

    // Reset held for two edges with an 8 on the input.
    drive_and_clock(1'b1, 4'd8);
    chk_both("reset_edge1", 7'b0000000);
    drive_and_clock(1'b1, 4'd8);
    chk_both("reset_edge2", 7'b0000000);
    drive_and_clock(1'b0, 4'd8);
    chk_both("release_8", 7'b1111111);

    // Full table sweep, one value per cycle.
    for (int i = 0; i < 16; i++) begin
      drive_and_clock(1'b0, vecs[i].in_bcd);
      chk_both($sformatf("table_%0d", i), vecs[i].exp_seg);
    end

    // Input glitch between edges must not reach the outputs.
    drive_and_clock(1'b0, 4'd1);
    chk_both("glitch_pre", 7'b0110000);
    #1 bcd = 4'd0;
    #1 chk_both("glitch_mid", 7'b0110000);
    #1 bcd = 4'd1;
    @(posedge clk);
    #1;
    chk_both("glitch_post", 7'b0110000);

    // Reset mid-stream while showing 5, then recovery.
    drive_and_clock(1'b0, 4'd5);
    chk_both("pre_reset_5", 7'b1011011);
    drive_and_clock(1'b1, 4'd5);
    chk_both("midreset_5", 7'b0000000);
    drive_and_clock(1'b0, 4'd5);
    chk_both("resume_5", 7'b1011011);

    // Change after reset to confirm one-cycle latency on a fresh value.
    drive_and_clock(1'b0, 4'd0);
    chk_both("latency_0", 7'b1111110);
    @(negedge clk);
    bcd = 4'd7;
    chk_both("hold_before_edge", 7'b1111110);
    @(posedge clk);
    #1;
    chk_both("latency_7", 7'b1110000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
